// File: rtl/tlul_arb_pkg.sv
// Helpers for the M:1 TL-UL round-robin socket.
//   ARB_MAX_HOSTS : widest host count the socket supports.
//   arb_idx_t     : host index wide enough for ARB_MAX_HOSTS.
//   rr_scan       : first requester found scanning ptr, ptr+1, ... mod m.
package tlul_arb_pkg;

  localparam int ARB_MAX_HOSTS = 8;

  typedef logic [2:0] arb_idx_t;

  // With no requester the pointer is returned; callers gate with |req.
  function automatic arb_idx_t rr_scan(input logic [ARB_MAX_HOSTS-1:0] req,
                                       input arb_idx_t                 ptr,
                                       input int                       m);
    arb_idx_t pick;
    logic     found;
    int       idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < ARB_MAX_HOSTS; k++) begin
      idx = (int'(ptr) + k) % m;
      if (k < m && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel structures shared by hosts, devices and the crossbar sockets.
//   tl_h2d_t : host-to-device A channel plus the host's D-channel ready.
//   tl_d2h_t : device-to-host D channel plus the device's A-channel ready.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_rr_arbiter_m1_if.sv
// Bus bundle between M TL-UL hosts and one shared TL-UL device port.
//   tl_h_i : host requests (M entries)     tl_h_o : host responses / a_ready
//   tl_d_o : request toward the device      tl_d_i : device response / a_ready
// slave  : view taken by the arbiter socket.
// master : view taken by whatever drives the hosts and models the device.
interface tlul_rr_arbiter_m1_if #(
  parameter int M = 2
) ();

  tlul_pkg::tl_h2d_t [M-1:0] tl_h_i;
  tlul_pkg::tl_d2h_t [M-1:0] tl_h_o;
  tlul_pkg::tl_h2d_t         tl_d_o;
  tlul_pkg::tl_d2h_t         tl_d_i;

  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );

  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );

endinterface

// File: rtl/tlul_arb_idx_fifo.sv
// Return-index FIFO: remembers which host issued each in-flight request.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   push_i, wdata_i    : enqueue a host index (ignored when full)
//   pop_i              : dequeue the head (ignored when empty)
//   rdata_o            : head entry
//   count_o            : number of stored entries
//   full_o, empty_o    : occupancy flags
module tlul_arb_idx_fifo #(
  parameter  int Width = 1,
  parameter  int Depth = 4,
  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    // push and pop together leave the count alone
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tlul_rr_arbiter_m1.sv
// M:1 TL-UL socket: round-robin A-channel grant with in-order D-channel
// return routing. The device must answer in request order.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   tl               : host and device TL-UL channels (slave view)
//   gnt_idx_o        : host granted on the A channel (valid with tl_d_o.a_valid)
//   outstanding_o    : accepted, unanswered requests
//   err_unexp_rsp_o  : one-cycle pulse after a response with nothing outstanding
module tlul_rr_arbiter_m1
  import tlul_pkg::*;
  import tlul_arb_pkg::*;
#(
  parameter  int M              = 2,
  parameter  int MaxOutstanding = 4,
  localparam int IdxW           = $clog2(M),
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  tlul_rr_arbiter_m1_if.slave        tl,
  output logic [IdxW-1:0]            gnt_idx_o,
  output logic [CntW-1:0]            outstanding_o,
  output logic                       err_unexp_rsp_o
);

  logic [M-1:0]    req;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [IdxW-1:0] gnt;
  logic [IdxW-1:0] head;
  logic            a_valid_out, a_hs;
  logic            d_ready_out, d_hs;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_cnt;

  always_comb begin
    for (int i = 0; i < M; i++) req[i] = tl.tl_h_i[i].a_valid;
  end

  always_comb begin
    // A pending stalled request keeps its grant until the device takes it.
    gnt = lock_q ? lock_idx_q
                 : IdxW'(rr_scan(ARB_MAX_HOSTS'(req), arb_idx_t'(rr_ptr_q), M));
    // Full blocks new grants even if a pop happens this cycle; the freed
    // slot becomes usable on the next cycle.
    a_valid_out = ~fifo_full & (lock_q ? tl.tl_h_i[lock_idx_q].a_valid : |req);
    a_hs        = a_valid_out & tl.tl_d_i.a_ready;
    // With nothing outstanding the device D channel is drained.
    d_ready_out = fifo_empty ? 1'b1 : tl.tl_h_i[head].d_ready;
    d_hs        = tl.tl_d_i.d_valid & d_ready_out & ~fifo_empty;
    err_d       = tl.tl_d_i.d_valid & fifo_empty;

    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (a_hs) begin
      lock_d = 1'b0;
    end else if (a_valid_out) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end

    rr_ptr_d = rr_ptr_q;
    if (a_hs) begin
      rr_ptr_d = (gnt == IdxW'(M - 1)) ? '0 : gnt + 1'b1;
    end
  end

  always_comb begin
    tl.tl_d_o         = tl.tl_h_i[gnt];
    tl.tl_d_o.a_valid = a_valid_out;
    tl.tl_d_o.d_ready = d_ready_out;
    for (int i = 0; i < M; i++) begin
      tl.tl_h_o[i]         = tl.tl_d_i;
      tl.tl_h_o[i].a_ready = a_valid_out & tl.tl_d_i.a_ready & (gnt == IdxW'(i));
      tl.tl_h_o[i].d_valid = tl.tl_d_i.d_valid & ~fifo_empty & (head == IdxW'(i));
    end
  end

  tlul_arb_idx_fifo #(
    .Width (IdxW),
    .Depth (MaxOutstanding)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (a_hs),
    .wdata_i (gnt),
    .pop_i   (d_hs),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  assign gnt_idx_o       = gnt;
  assign outstanding_o   = fifo_cnt;
  assign err_unexp_rsp_o = err_q;

endmodule

// File: tb/tb_tlul_rr_arbiter_m1.sv
module tb_tlul_rr_arbiter_m1;
  import tlul_pkg::*;

  logic       clk_i;
  logic       rst_ni;
  logic [0:0] gnt_idx_o;
  logic [2:0] outstanding_o;
  logic       err_unexp_rsp_o;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int          host;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  tlul_rr_arbiter_m1_if #(.M(2)) bus ();

  tlul_rr_arbiter_m1 #(.M(2), .MaxOutstanding(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .tl              (bus),
    .gnt_idx_o       (gnt_idx_o),
    .outstanding_o   (outstanding_o),
    .err_unexp_rsp_o (err_unexp_rsp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic set_host(input int h, input logic v, input logic [31:0] addr);
    bus.tl_h_i[h[0]].a_valid   = v;
    bus.tl_h_i[h[0]].a_address = addr;
  endtask

  // Called just after a rising edge: one response beat, handshaken on the next edge.
  task automatic dev_rsp(input logic [31:0] data);
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = data;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    bus.tl_d_i.d_valid = 1'b0;
  endtask

  // Response monitor: any host d_valid must match the head of the scoreboard.
  int   mon_nv;
  int   mon_hv;
  exp_t mon_e;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      mon_nv = 0;
      mon_hv = 0;
      for (int i = 0; i < 2; i++) begin
        if (bus.tl_h_o[i].d_valid) begin
          mon_nv++;
          mon_hv = i;
        end
      end
      if (mon_nv > 0) begin
        check_val("d_onehot", mon_nv, 1);
        if (sb_q.size() == 0) begin
          check_val("d_unexp_sb", sb_q.size(), 1);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("d_host", mon_hv, mon_e.host);
          check_val("d_data", bus.tl_h_o[mon_hv[0]].d_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.tl_h_i = '0;
    bus.tl_d_i = '0;
    bus.tl_h_i[0].d_ready = 1'b1;
    bus.tl_h_i[1].d_ready = 1'b1;
    rst_ni = 1'b0;
    step();
    step();
    settle();
    check_val("rst_cnt", 32'(outstanding_o), 0);
    check_val("rst_avalid", 32'(bus.tl_d_o.a_valid), 0);
    check_val("rst_err", 32'(err_unexp_rsp_o), 0);
    check_val("rst_aready", 32'({bus.tl_h_o[1].a_ready, bus.tl_h_o[0].a_ready}), 0);
    check_val("rst_dvalid", 32'({bus.tl_h_o[1].d_valid, bus.tl_h_o[0].d_valid}), 0);
    step();
    rst_ni = 1'b1;

    // Fairness: both hosts always requesting, device always ready.
    bus.tl_d_i.a_ready = 1'b1;
    set_host(0, 1'b1, 32'h100);
    set_host(1, 1'b1, 32'h200);
    for (int k = 0; k < 4; k++) begin
      settle();
      check_val("fair_gnt", 32'(gnt_idx_o), k % 2);
      check_val("fair_addr", bus.tl_d_o.a_address, (k % 2 == 0) ? 32'h100 : 32'h200);
      check_val("fair_cnt", 32'(outstanding_o), k);
      check_val("fair_aready", 32'(bus.tl_h_o[k % 2].a_ready), 1);
      sb_q.push_back('{k % 2, 32'hD0 + k});
      step();
    end
    settle();
    check_val("full_avalid", 32'(bus.tl_d_o.a_valid), 0);
    check_val("full_cnt", 32'(outstanding_o), 4);
    check_val("full_aready", 32'({bus.tl_h_o[1].a_ready, bus.tl_h_o[0].a_ready}), 0);
    step();
    set_host(0, 1'b0, 32'h0);
    set_host(1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) dev_rsp(32'hD0 + k);
    settle();
    check_val("fair_drained", 32'(outstanding_o), 0);
    step();

    // Lock: host1 stalled by the device while host0 joins.
    bus.tl_d_i.a_ready = 1'b0;
    set_host(1, 1'b1, 32'h210);
    settle();
    check_val("lock_gnt0", 32'(gnt_idx_o), 1);
    step();
    set_host(0, 1'b1, 32'h110);
    settle();
    check_val("lock_gnt1", 32'(gnt_idx_o), 1);
    check_val("lock_h0_aready", 32'(bus.tl_h_o[0].a_ready), 0);
    check_val("lock_addr", bus.tl_d_o.a_address, 32'h210);
    step();
    settle();
    check_val("lock_gnt2", 32'(gnt_idx_o), 1);
    step();
    bus.tl_d_i.a_ready = 1'b1;
    settle();
    check_val("lock_accept_gnt", 32'(gnt_idx_o), 1);
    check_val("lock_accept_rdy", 32'(bus.tl_h_o[1].a_ready), 1);
    sb_q.push_back('{1, 32'hE1});
    step();
    set_host(1, 1'b0, 32'h0);
    settle();
    check_val("lock_next_gnt", 32'(gnt_idx_o), 0);
    check_val("lock_next_avalid", 32'(bus.tl_d_o.a_valid), 1);
    sb_q.push_back('{0, 32'hE0});
    step();
    set_host(0, 1'b0, 32'h0);
    dev_rsp(32'hE1);
    dev_rsp(32'hE0);

    // Full with a simultaneous pop.
    set_host(1, 1'b1, 32'h220);
    for (int k = 0; k < 4; k++) begin
      settle();
      check_val("fill_gnt", 32'(gnt_idx_o), 1);
      sb_q.push_back('{1, 32'hF0 + k});
      step();
    end
    set_host(1, 1'b0, 32'h0);
    set_host(0, 1'b1, 32'h120);
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = 32'hF0;
    settle();
    check_val("fullpop_avalid", 32'(bus.tl_d_o.a_valid), 0);
    check_val("fullpop_h0_rdy", 32'(bus.tl_h_o[0].a_ready), 0);
    check_val("fullpop_cnt", 32'(outstanding_o), 4);
    step();
    bus.tl_d_i.d_valid = 1'b0;
    settle();
    check_val("afterpop_cnt", 32'(outstanding_o), 3);
    check_val("afterpop_avalid", 32'(bus.tl_d_o.a_valid), 1);
    check_val("afterpop_gnt", 32'(gnt_idx_o), 0);
    sb_q.push_back('{0, 32'hF4});
    step();
    set_host(0, 1'b0, 32'h0);
    settle();
    check_val("refill_cnt", 32'(outstanding_o), 4);
    step();
    for (int k = 1; k < 5; k++) dev_rsp(32'hF0 + k);

    // Response routing: host1, host0, host1.
    set_host(1, 1'b1, 32'h230);
    settle();
    check_val("route_gnt_a", 32'(gnt_idx_o), 1);
    sb_q.push_back('{1, 32'hA1});
    step();
    set_host(1, 1'b0, 32'h0);
    set_host(0, 1'b1, 32'h130);
    settle();
    check_val("route_gnt_b", 32'(gnt_idx_o), 0);
    sb_q.push_back('{0, 32'hB0});
    step();
    set_host(0, 1'b0, 32'h0);
    set_host(1, 1'b1, 32'h240);
    settle();
    check_val("route_gnt_c", 32'(gnt_idx_o), 1);
    sb_q.push_back('{1, 32'hC1});
    step();
    set_host(1, 1'b0, 32'h0);
    settle();
    check_val("route_cnt", 32'(outstanding_o), 3);
    step();
    dev_rsp(32'hA1);
    dev_rsp(32'hB0);
    dev_rsp(32'hC1);
    settle();
    check_val("route_sb_empty", sb_q.size(), 0);
    step();

    // Unexpected response with nothing outstanding.
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = 32'h55;
    settle();
    check_val("unexp_dready", 32'(bus.tl_d_o.d_ready), 1);
    check_val("unexp_dvalid", 32'({bus.tl_h_o[1].d_valid, bus.tl_h_o[0].d_valid}), 0);
    check_val("unexp_err_pre", 32'(err_unexp_rsp_o), 0);
    step();
    bus.tl_d_i.d_valid = 1'b0;
    settle();
    check_val("unexp_err", 32'(err_unexp_rsp_o), 1);
    step();
    settle();
    check_val("unexp_err_clr", 32'(err_unexp_rsp_o), 0);
    step();

    // Reset with two requests in flight.
    set_host(0, 1'b1, 32'h140);
    step();
    step();
    set_host(0, 1'b0, 32'h0);
    settle();
    check_val("mid_cnt_pre", 32'(outstanding_o), 2);
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    settle();
    check_val("mid_cnt", 32'(outstanding_o), 0);
    check_val("mid_avalid", 32'(bus.tl_d_o.a_valid), 0);
    step();
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = 32'h66;
    settle();
    check_val("mid_dvalid", 32'({bus.tl_h_o[1].d_valid, bus.tl_h_o[0].d_valid}), 0);
    step();
    bus.tl_d_i.d_valid = 1'b0;
    settle();
    check_val("mid_err", 32'(err_unexp_rsp_o), 1);
    step();

    check_val("sb_final_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tlul_rr_arbiter_m1.md
Name: tlul_rr_arbiter_m1

Overview:
- Shares one TL-UL device port among M TL-UL hosts using a fair round-robin grant.
- Tracks outstanding requests in order and routes each D-channel response back to the host that issued it.
- Drop-in replacement for the per-device M:1 sockets in the peripheral crossbar (ICCM, DCCM, GPIO, PLIC, ...), where the LSU and debug SBA hosts contend for the same device.
- Attached devices respond in request order; the block relies on that and does not rewrite a_source.

Parameters:
- M, 2, number of host ports; legal range 2..8.
- MaxOutstanding, 4, depth of the return-index FIFO (max in-flight requests); power of two, 1..16.
- IdxW, $clog2(M), derived width of the host index; not overridden.
- CntW, $clog2(MaxOutstanding+1), derived width of the outstanding count.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; synchronous, active-low (sampled on rising clk_i).
- tl_h_i  input  M x tl_h2d_t  host-side requests.
- tl_h_o  output  M x tl_d2h_t  host-side responses and a_ready.
- tl_d_o  output  tl_h2d_t  device-side request.
- tl_d_i  input  tl_d2h_t  device-side response and a_ready.
- gnt_idx_o  output  IdxW  host currently granted on the A channel; valid when tl_d_o.a_valid=1.
- outstanding_o  output  CntW  number of accepted, unanswered requests.
- err_unexp_rsp_o  output  1  one-cycle pulse when the device returns d_valid with no outstanding request.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - rr_ptr=0, lock=0, FIFO pointers=0, count=0, err_unexp_rsp_o=0.
  - Combinational outputs then give tl_d_o.a_valid=0, all tl_h_o[i].a_ready=0, all tl_h_o[i].d_valid=0.
  - Reset applied mid-transaction discards all tracking; a device response arriving later counts as unexpected.
- A-channel arbitration:
  - Purely combinational, zero added latency.
  - Candidates are hosts with a_valid=1. Pick the first candidate scanning rr_ptr, rr_ptr+1, ... mod M.
  - tl_d_o carries the granted host's A fields with a_valid=1; only the granted host sees a_ready = tl_d_i.a_ready. All other hosts get a_ready=0.
- Lock:
  - If tl_d_o.a_valid=1 and tl_d_i.a_ready=0, register lock=1 and lock_idx=granted.
  - While lock=1, the grant is forced to lock_idx regardless of other requesters (TL-UL A-channel stability).
  - Lock clears on the accepting handshake.
- Pointer update: on an A handshake (a_valid & a_ready at the device), rr_ptr <= (granted+1) mod M. No update without a handshake.
- Backpressure:
  - When count==MaxOutstanding, no grant is issued: tl_d_o.a_valid=0 and all a_ready=0.
  - This holds even if a response pops in the same cycle; the grant resumes the next cycle.
  - An existing lock stays set while full.
- Return FIFO:
  - Push the granted index on an A handshake; pop on a D handshake (tl_d_i.d_valid & tl_d_o.d_ready).
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo MaxOutstanding.
- D-channel routing:
  - When count>0, tl_h_o[head].d_* = tl_d_i.d_* and tl_d_o.d_ready = tl_h_i[head].d_ready. Other hosts get d_valid=0.
  - When count==0, tl_d_o.d_ready=1 (drain) and all host d_valid=0. A d_valid seen in this state pulses err_unexp_rsp_o the next cycle (registered) and is discarded.
- outstanding_o = count (registered).

Decomposition:
- tlul_arb_pkg: arb_idx_t typedef, the round-robin scan function, and ARB_MAX_HOSTS=8.
- tl_h2d_t and tl_d2h_t come from tlul_pkg.
- One sub-module: tlul_arb_idx_fifo, a synchronous FIFO (width IdxW, depth MaxOutstanding) with count, full and empty outputs and synchronous active-low reset.

Test Plan:
- Fairness: M=2, both hosts hold a_valid continuously, device a_ready=1 -> grants alternate 0,1,0,1; gnt_idx_o toggles every cycle; outstanding_o rises by 1 per cycle until 4, then a_valid drops.
- Lock: host1 requests, device a_ready=0 for 3 cycles, host0 raises a_valid in cycle 2 -> gnt_idx_o stays 1 for all 3 cycles; host0 is granted on the cycle after acceptance.
- Full with simultaneous pop: 4 requests accepted and unanswered, then in one cycle d_valid=1, d_ready=1 with a pending host0 request -> no grant that cycle, outstanding_o=3, grant the next cycle, outstanding_o back to 4.
- Response routing: requests issued in order host1, host0, host1 with distinct d_data 0xA1, 0xB0, 0xC1 -> host1, host0, host1 receive the data in that order; the non-target host never sees d_valid=1.
- Unexpected response: count=0, device asserts d_valid -> tl_d_o.d_ready=1, no host d_valid, err_unexp_rsp_o=1 for exactly one cycle.
- Mid-operation reset: 2 outstanding, rst_ni=0 for one edge -> outstanding_o=0, tl_d_o.a_valid=0; a subsequent device d_valid produces err_unexp_rsp_o.
